fpu_job_dispatcher: RTL and testbench

Parametrised job queue and dispatcher between the job manager and a bank of `NUM_FPU` FPU channels. It accepts FPU jobs, each an `op_id` plus four flattened operand memory handles a/b/c/d, into a `DEPTH`-entry FIFO and tags each job with a sequence number. It dispatches jobs round-robin to idle channels and reports completions one per cycle. It supersedes the single-channel job-manager/FPU interface.

---
 rtl/fpu_job_dispatcher.sv | 158 +++++++++++++++
 tb/tb_fpu_job_dispatcher.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_job_dispatcher.sv
// Job FIFO plus round-robin dispatcher feeding NUM_FPU FPU channels.
// Jobs are tagged on entry, and each channel's completion is reported once, lowest channel first.
module fpu_job_dispatcher #(
  parameter int NUM_FPU  = 2,
  parameter int DEPTH    = 4,
  parameter int HANDLE_W = 32,
  parameter int TAG_W    = 8,
  localparam int CHAN_W  = (NUM_FPU > 1) ? $clog2(NUM_FPU) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [5:0]                   job_op,
  input  logic [HANDLE_W-1:0]          job_a,
  input  logic [HANDLE_W-1:0]          job_b,
  input  logic [HANDLE_W-1:0]          job_c,
  input  logic [HANDLE_W-1:0]          job_d,
  output logic [TAG_W-1:0]             job_tag,
  output logic [NUM_FPU-1:0]           fpu_start,
  output logic [6*NUM_FPU-1:0]         fpu_op,
  output logic [HANDLE_W*NUM_FPU-1:0]  fpu_a,
  output logic [HANDLE_W*NUM_FPU-1:0]  fpu_b,
  output logic [HANDLE_W*NUM_FPU-1:0]  fpu_c,
  output logic [HANDLE_W*NUM_FPU-1:0]  fpu_d,
  input  logic [NUM_FPU-1:0]           fpu_done,
  output logic                         done_valid,
  output logic [CHAN_W-1:0]            done_chan,
  output logic [TAG_W-1:0]             done_tag,
  output logic [NUM_FPU-1:0]           busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [5:0] OP_NOOP = 6'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, REPORT = 2'd2} chan_state_e;

  typedef struct packed {
    logic [5:0]          op;
    logic [HANDLE_W-1:0] a;
    logic [HANDLE_W-1:0] b;
    logic [HANDLE_W-1:0] c;
    logic [HANDLE_W-1:0] d;
    logic [TAG_W-1:0]    tag;
  } job_t;

  job_t              mem [DEPTH];
  job_t              head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [TAG_W-1:0]  tag_cnt;
  logic [CHAN_W-1:0] rr_ptr;
  chan_state_e       state [NUM_FPU];
  logic [TAG_W-1:0]  chan_tag [NUM_FPU];

  logic              push, pop;
  logic              dispatch_en;
  logic [CHAN_W-1:0] dispatch_chan;
  logic              rep_next_valid;
  logic [CHAN_W-1:0] rep_next_chan;

  assign job_ready = !reset && (count != FULL_COUNT);
  assign job_tag   = tag_cnt;
  assign push      = job_valid && job_ready && (job_op != OP_NOOP);
  assign pop       = dispatch_en;
  assign head      = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < NUM_FPU; i++) busy[i] = (state[i] != IDLE);
  end

  // Walk downward so the smallest offset from rr_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dispatch_en   = 1'b0;
    dispatch_chan = '0;
    for (int k = NUM_FPU - 1; k >= 0; k--) begin
      if (count != '0 && state[(int'(rr_ptr) + k) % NUM_FPU] == IDLE) begin
        dispatch_en   = 1'b1;
        dispatch_chan = CHAN_W'((int'(rr_ptr) + k) % NUM_FPU);
      end
    end
  end

  // Channels that will sit in REPORT next cycle; the lowest one is reported then.
  always_comb begin
    rep_next_valid = 1'b0;
    rep_next_chan  = '0;
    for (int i = NUM_FPU - 1; i >= 0; i--) begin
      if ((state[i] == REPORT && !(done_valid && done_chan == CHAN_W'(i))) ||
          (state[i] == RUN && fpu_done[i])) begin
        rep_next_valid = 1'b1;
        rep_next_chan  = CHAN_W'(i);
      end
    end
  end

  // NOTE: the FIFO storage has no reset; occupancy is tracked by count and pointers alone.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{op: job_op, a: job_a, b: job_b, c: job_c, d: job_d, tag: tag_cnt};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tag_cnt    <= '0;
      rr_ptr     <= '0;
      fpu_start  <= '0;
      fpu_op     <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_c      <= '0;
      fpu_d      <= '0;
      done_valid <= 1'b0;
      done_chan  <= '0;
      done_tag   <= '0;
      for (int i = 0; i < NUM_FPU; i++) begin
        state[i]    <= IDLE;
        chan_tag[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tag_cnt <= tag_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

      for (int i = 0; i < NUM_FPU; i++) begin
        if (state[i] == RUN && fpu_done[i])
          state[i] <= REPORT;
        else if (state[i] == REPORT && done_valid && done_chan == CHAN_W'(i))
          state[i] <= IDLE;
      end

      fpu_start <= '0;
      if (dispatch_en) begin
        state[dispatch_chan]                       <= RUN;
        chan_tag[dispatch_chan]                    <= head.tag;
        fpu_start[dispatch_chan]                   <= 1'b1;
        fpu_op[dispatch_chan*6 +: 6]               <= head.op;
        fpu_a[dispatch_chan*HANDLE_W +: HANDLE_W]  <= head.a;
        fpu_b[dispatch_chan*HANDLE_W +: HANDLE_W]  <= head.b;
        fpu_c[dispatch_chan*HANDLE_W +: HANDLE_W]  <= head.c;
        fpu_d[dispatch_chan*HANDLE_W +: HANDLE_W]  <= head.d;
        rr_ptr <= (dispatch_chan == CHAN_W'(NUM_FPU - 1)) ? '0 : dispatch_chan + CHAN_W'(1);
      end

      done_valid <= rep_next_valid;
      done_chan  <= rep_next_chan;
      done_tag   <= rep_next_valid ? chan_tag[rep_next_chan] : '0;
    end
  end

endmodule

// File: tb/tb_fpu_job_dispatcher.sv
// Bench for fpu_job_dispatcher: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model of the dispatcher.
module tb_fpu_job_dispatcher;

  localparam int NUM_FPU  = 2;
  localparam int DEPTH    = 4;
  localparam int HANDLE_W = 32;
  localparam int TAG_W    = 8;
  localparam int CHAN_W   = (NUM_FPU > 1) ? $clog2(NUM_FPU) : 1;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        job_valid = 1'b0;
  logic                        job_ready;
  logic [5:0]                  job_op = '0;
  logic [HANDLE_W-1:0]         job_a = '0, job_b = '0, job_c = '0, job_d = '0;
  logic [TAG_W-1:0]            job_tag;
  logic [NUM_FPU-1:0]          fpu_start;
  logic [6*NUM_FPU-1:0]        fpu_op;
  logic [HANDLE_W*NUM_FPU-1:0] fpu_a, fpu_b, fpu_c, fpu_d;
  logic [NUM_FPU-1:0]          fpu_done = '0;
  logic                        done_valid;
  logic [CHAN_W-1:0]           done_chan;
  logic [TAG_W-1:0]            done_tag;
  logic [NUM_FPU-1:0]          busy;

  fpu_job_dispatcher #(
    .NUM_FPU(NUM_FPU), .DEPTH(DEPTH), .HANDLE_W(HANDLE_W), .TAG_W(TAG_W)
  ) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d), .job_tag(job_tag),
    .fpu_start(fpu_start), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_d(fpu_d),
    .fpu_done(fpu_done), .done_valid(done_valid), .done_chan(done_chan),
    .done_tag(done_tag), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]          op;
    logic [HANDLE_W-1:0] a, b, c, d;
    logic [TAG_W-1:0]    tag;
  } job_t;

  // Reference model: waiting jobs, per-channel job and phase (0 free, 1 computing, 2 awaiting report).
  job_t               jq[$];
  job_t               cj  [NUM_FPU];
  int                 cst [NUM_FPU];
  int                 rr;
  logic [TAG_W-1:0]   m_tag;
  logic [NUM_FPU-1:0] e_start;
  logic               e_dv;
  logic [CHAN_W-1:0]  e_dchan;
  logic [TAG_W-1:0]   e_dtag;

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    jq.delete();
    rr = 0; m_tag = '0; e_start = '0; e_dv = 1'b0; e_dchan = '0; e_dtag = '0;
    for (int i = 0; i < NUM_FPU; i++) begin
      cst[i] = 0;
      cj[i]  = '0;
    end
  endtask

  // One clock: check the outputs of the last edge, apply new inputs, advance the model.
  task automatic cycle(input logic rst, input logic v, input logic [5:0] op,
                       input logic [HANDLE_W-1:0] a, input logic [HANDLE_W-1:0] b,
                       input logic [HANDLE_W-1:0] c, input logic [HANDLE_W-1:0] d,
                       input logic [NUM_FPU-1:0] dn);
    logic [NUM_FPU-1:0]          e_busy;
    logic [6*NUM_FPU-1:0]        e_op;
    logic [HANDLE_W*NUM_FPU-1:0] e_a, e_b, e_c, e_d;
    logic                        e_ready;
    int                          nst [NUM_FPU];
    int                          pick;
    @(negedge clock);
    for (int i = 0; i < NUM_FPU; i++) begin
      e_busy[i]                     = (cst[i] != 0);
      e_op[i*6 +: 6]                = cj[i].op;
      e_a[i*HANDLE_W +: HANDLE_W]   = cj[i].a;
      e_b[i*HANDLE_W +: HANDLE_W]   = cj[i].b;
      e_c[i*HANDLE_W +: HANDLE_W]   = cj[i].c;
      e_d[i*HANDLE_W +: HANDLE_W]   = cj[i].d;
    end
    vectors++;
    if (fpu_start !== e_start) begin
      miscompares++; $display("FAIL fpu_start @%0t: got %b expected %b", $time, fpu_start, e_start);
    end
    vectors++;
    if (busy !== e_busy) begin
      miscompares++; $display("FAIL busy @%0t: got %b expected %b", $time, busy, e_busy);
    end
    vectors++;
    if ({done_valid, done_chan, done_tag} !== {e_dv, e_dchan, e_dtag}) begin
      miscompares++;
      $display("FAIL done @%0t: got v=%b ch=%0d tag=%0d expected v=%b ch=%0d tag=%0d",
               $time, done_valid, done_chan, done_tag, e_dv, e_dchan, e_dtag);
    end
    vectors++;
    if (job_tag !== m_tag) begin
      miscompares++; $display("FAIL job_tag @%0t: got %0d expected %0d", $time, job_tag, m_tag);
    end
    vectors++;
    if ({fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== {e_op, e_a, e_b, e_c, e_d}) begin
      miscompares++;
      $display("FAIL chan_data @%0t: got op=%h a=%h expected op=%h a=%h", $time, fpu_op, fpu_a, e_op, e_a);
    end

    reset = rst; job_valid = v; job_op = op;
    job_a = a; job_b = b; job_c = c; job_d = d; fpu_done = dn;
    #1;
    e_ready = !rst && (jq.size() < DEPTH);
    vectors++;
    if (job_ready !== e_ready) begin
      miscompares++; $display("FAIL job_ready @%0t: got %b expected %b", $time, job_ready, e_ready);
    end

    if (rst) begin
      model_reset();
    end else begin
      nst = cst;
      if (e_dv) nst[e_dchan] = 0;
      for (int i = 0; i < NUM_FPU; i++)
        if (cst[i] == 1 && dn[i]) nst[i] = 2;
      e_start = '0;
      pick = -1;
      if (jq.size() > 0)
        for (int k = 0; k < NUM_FPU; k++)
          if (pick < 0 && cst[(rr + k) % NUM_FPU] == 0) pick = (rr + k) % NUM_FPU;
      if (pick >= 0) begin
        cj[pick]      = jq.pop_front();
        nst[pick]     = 1;
        e_start[pick] = 1'b1;
        rr            = (pick + 1) % NUM_FPU;
      end
      e_dv = 1'b0; e_dchan = '0; e_dtag = '0;
      for (int i = NUM_FPU - 1; i >= 0; i--)
        if (nst[i] == 2) begin
          e_dv = 1'b1; e_dchan = CHAN_W'(i); e_dtag = cj[i].tag;
        end
      cst = nst;
      if (e_ready && v && op != 6'd0) begin
        jq.push_back('{op: op, a: a, b: b, c: c, d: d, tag: m_tag});
        m_tag = m_tag + 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic [NUM_FPU-1:0] dn = '0);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 6'd0, '0, '0, '0, '0, dn);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 6'd0, '0, '0, '0, '0, '0);
  endtask

  task automatic job(input logic [5:0] op);
    cycle(1'b0, 1'b1, op, $urandom, $urandom, $urandom, $urandom, '0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (job_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready_low: got %b expected 0", job_ready);
    end
    do_reset();
    idle(1);
    vectors++;
    if ({job_ready, busy, job_tag, done_valid} !== {1'b1, {NUM_FPU{1'b0}}, {TAG_W{1'b0}}, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got ready=%b busy=%b tag=%0d dv=%b", job_ready, busy, job_tag, done_valid);
    end
  endtask

  task automatic test_single_job();
    do_reset();
    idle(1);
    cycle(1'b0, 1'b1, 6'd1, 32'h10, 32'h20, 32'h30, 32'h40, '0);
    vectors++;
    if (job_tag !== 8'd0) begin
      miscompares++; $display("FAIL single_tag: got %0d expected 0", job_tag);
    end
    idle(2);
    vectors++;
    if ({fpu_start, fpu_op[5:0], fpu_a[31:0], fpu_b[31:0], fpu_c[31:0], fpu_d[31:0]} !==
        {2'b01, 6'd1, 32'h10, 32'h20, 32'h30, 32'h40}) begin
      miscompares++;
      $display("FAIL single_start: got start=%b op=%0d a=%h d=%h", fpu_start, fpu_op[5:0], fpu_a[31:0], fpu_d[31:0]);
    end
    idle(3);
    idle(1, 2'b01);
    idle(1);
    vectors++;
    if ({done_valid, done_chan, done_tag} !== {1'b1, 1'b0, 8'd0}) begin
      miscompares++; $display("FAIL single_done: got v=%b ch=%0d tag=%0d", done_valid, done_chan, done_tag);
    end
    idle(1);
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL single_idle: got busy0=%b expected 0", busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    job(6'd2); job(6'd2); job(6'd2);
    vectors++;
    if (fpu_start !== 2'b01) begin
      miscompares++; $display("FAIL b2b_first: got %b expected 01", fpu_start);
    end
    idle(1);
    vectors++;
    if (fpu_start !== 2'b10) begin
      miscompares++; $display("FAIL b2b_second: got %b expected 10", fpu_start);
    end
    idle(2);
    idle(1, 2'b10);
    idle(3);
    vectors++;
    if ({fpu_start, fpu_op[11:6]} !== {2'b10, 6'd2}) begin
      miscompares++; $display("FAIL b2b_third: got start=%b op1=%0d expected 10/2", fpu_start, fpu_op[11:6]);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) job(6'd4);
    vectors++;
    if (job_ready !== 1'b0) begin
      miscompares++; $display("FAIL fill_full: got ready=%b expected 0", job_ready);
    end
    cycle(1'b0, 1'b1, 6'd4, '0, '0, '0, '0, 2'b01);
    job(6'd4);
    job(6'd4);
    vectors++;
    if (job_ready !== 1'b0) begin
      miscompares++; $display("FAIL fill_still_full: got ready=%b expected 0", job_ready);
    end
    job(6'd4);
    vectors++;
    if (job_ready !== 1'b1) begin
      miscompares++; $display("FAIL fill_reopen: got ready=%b expected 1", job_ready);
    end
    idle(2);
  endtask

  task automatic test_simultaneous_done();
    do_reset();
    job(6'd5); job(6'd5);
    idle(3);
    idle(1, 2'b11);
    idle(1);
    vectors++;
    if ({done_valid, done_chan, done_tag} !== {1'b1, 1'b0, 8'd0}) begin
      miscompares++; $display("FAIL simul_first: got v=%b ch=%0d tag=%0d", done_valid, done_chan, done_tag);
    end
    idle(1);
    vectors++;
    if ({done_valid, done_chan, done_tag} !== {1'b1, 1'b1, 8'd1}) begin
      miscompares++; $display("FAIL simul_second: got v=%b ch=%0d tag=%0d", done_valid, done_chan, done_tag);
    end
    idle(1);
    vectors++;
    if ({done_valid, busy} !== 3'b000) begin
      miscompares++; $display("FAIL simul_after: got v=%b busy=%b", done_valid, busy);
    end
  endtask

  task automatic test_noop();
    do_reset();
    job(6'd3);
    job(6'd0);
    job(6'd3);
    vectors++;
    if (job_tag !== 8'd1) begin
      miscompares++; $display("FAIL noop_tag: got %0d expected 1", job_tag);
    end
    idle(1);
    vectors++;
    if (fpu_start !== 2'b00) begin
      miscompares++; $display("FAIL noop_no_dispatch: got %b expected 00", fpu_start);
    end
    idle(1);
    vectors++;
    if ({fpu_start, fpu_op[11:6]} !== {2'b10, 6'd3}) begin
      miscompares++; $display("FAIL noop_second: got start=%b op1=%0d", fpu_start, fpu_op[11:6]);
    end
    idle(1, 2'b11);
    idle(4);
  endtask

  task automatic test_reset_midop();
    do_reset();
    job(6'd6); job(6'd6);
    idle(3);
    idle(1, 2'b10);
    do_reset();
    idle(1);
    vectors++;
    if ({done_valid, busy} !== 3'b000) begin
      miscompares++; $display("FAIL midop_flush: got v=%b busy=%b", done_valid, busy);
    end
    idle(1, 2'b01);
    idle(2);
    vectors++;
    if ({done_valid, busy} !== 3'b000) begin
      miscompares++; $display("FAIL midop_ignore: got v=%b busy=%b", done_valid, busy);
    end
    job(6'd6);
    vectors++;
    if (job_tag !== 8'd0) begin
      miscompares++; $display("FAIL midop_tag: got %0d expected 0", job_tag);
    end
    idle(3);
  endtask

  task automatic test_random();
    logic [NUM_FPU-1:0] dn;
    logic [5:0]         op;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_FPU; i++) dn[i] = ($urandom_range(0, 3) == 0);
      op = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 14));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, op,
            $urandom, $urandom, $urandom, $urandom, dn);
    end
    idle(12);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_job();
    test_back_to_back();
    test_fill();
    test_simultaneous_done();
    test_noop();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
